// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package mem_stage_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_e;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  localparam int         TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and memory (slave).
interface mem_access_stage_if #(parameter int NBits = 32);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [NBits-1:0] req_addr;
  logic [NBits-1:0] req_wdata;
  logic             rsp_valid;
  logic [NBits-1:0] rsp_rdata;

  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/mem_timeout_counter.sv
// Cycle counter for an outstanding access; expired fires on the LIMIT-th enabled cycle.
module mem_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)                  cnt <= '0;
    else if (en && cnt != CW'(LIMIT))  cnt <= cnt + CW'(1);
  end

  // >= covers a read accepted on its last allowed cycle: WAIT then aborts at once
  assign expired = en && (cnt >= CW'(LIMIT - 1));
endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: issues EX/MEM loads/stores to data memory and stalls the pipe until done.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int NBits   = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                EX_MEM_valid_i,
  input  logic                EX_MEM_mem_read_i,
  input  logic                EX_MEM_mem_write_i,
  input  logic [NBits-1:0]    EX_MEM_alu_result_i,
  input  logic [NBits-1:0]    EX_MEM_write_data_i,
  mem_access_stage_if.master  dmem,
  output logic [NBits-1:0]    read_data_o,
  output logic                mem_stall_o,
  output logic                misalign_o,
  output logic                timeout_o
);
  mem_state_e state, state_n;
  logic       access, aligned, expired;

  assign access  = EX_MEM_valid_i && (EX_MEM_mem_read_i || EX_MEM_mem_write_i);
  assign aligned = (EX_MEM_alu_result_i[1:0] & WORD_ALIGN_MASK) == 2'b00;

  mem_timeout_counter #(.LIMIT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == IDLE),
    .en      (state == REQ || state == WAIT),
    .expired (expired)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (access && aligned) state_n = REQ;
      REQ: begin
        if (dmem.req_ready)  state_n = dmem.req_we ? DONE : WAIT;
        else if (expired)    state_n = DONE;
      end
      WAIT: if (dmem.rsp_valid || expired) state_n = DONE;
      // DONE lets EX/MEM advance so the same instruction is never re-issued
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      dmem.req_valid <= 1'b0;
      dmem.req_we    <= 1'b0;
      dmem.req_addr  <= '0;
      dmem.req_wdata <= '0;
      read_data_o    <= '0;
      misalign_o     <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (access) begin
          if (aligned) begin
            dmem.req_valid <= 1'b1;
            dmem.req_we    <= EX_MEM_mem_write_i;
            dmem.req_addr  <= {EX_MEM_alu_result_i[NBits-1:2], 2'b00};
            dmem.req_wdata <= EX_MEM_write_data_i;
          end else begin
            misalign_o  <= 1'b1;
            read_data_o <= '0;
          end
        end
        REQ: begin
          if (dmem.req_ready) begin
            dmem.req_valid <= 1'b0;
          end else if (expired) begin
            dmem.req_valid <= 1'b0;
            timeout_o      <= 1'b1;
            read_data_o    <= '0;
          end
        end
        WAIT: begin
          if (dmem.rsp_valid) begin
            read_data_o <= dmem.rsp_rdata;
          end else if (expired) begin
            timeout_o   <= 1'b1;
            read_data_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_stall_o = !reset &&
                       ((state == IDLE && access && aligned) || state == REQ || state == WAIT);
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected requests/read data queued at drive time.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_rd, ex_wr;
  logic [31:0] ex_addr, ex_wdata;
  logic [31:0] read_data;
  logic        stall, misalign, tmo;

  mem_access_stage_if #(.NBits(32)) dmem ();

  mem_access_stage #(.NBits(32), .TIMEOUT(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .EX_MEM_valid_i      (ex_valid),
    .EX_MEM_mem_read_i   (ex_rd),
    .EX_MEM_mem_write_i  (ex_wr),
    .EX_MEM_alu_result_i (ex_addr),
    .EX_MEM_write_data_i (ex_wdata),
    .dmem                (dmem),
    .read_data_o         (read_data),
    .mem_stall_o         (stall),
    .misalign_o          (misalign),
    .timeout_o           (tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] exp_rd;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Request monitor: fields must match the queued request on every REQ cycle
  always @(negedge clk) begin
    if (dmem.req_valid) begin
      chk("req expected", 32'(req_q.size() > 0), 32'd1);
      if (req_q.size() > 0) begin
        chk("req we",    32'(dmem.req_we), 32'(req_q[0].we));
        chk("req addr",  dmem.req_addr,    req_q[0].addr);
        chk("req wdata", dmem.req_wdata,   req_q[0].wdata);
        if (dmem.req_ready) void'(req_q.pop_front());
      end
    end
  end

  // Runs one instruction in EX/MEM through to the cycle after its last stall cycle.
  // rsp_gap: cycles after acceptance before the read response (-1 = never).
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int rdy_dly, input int rsp_gap,
                           input logic [31:0] rdata, input int exp_stall);
    int stalls = 0, vcyc = 0, since = -1;
    bit done = 0, hs, seen;
    if (addr[1:0] != 2'b00) begin
      exp_rd = '0;
    end else begin
      req_q.push_back('{we: wr, addr: addr, wdata: wdata});
      if (!wr) exp_rd = (rsp_gap >= 0) ? rdata : 32'h0;
    end
    rd_q.push_back(exp_rd);
    ex_valid = 1'b1; ex_rd = rd; ex_wr = wr; ex_addr = addr; ex_wdata = wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      dmem.req_ready = dmem.req_valid && (vcyc >= rdy_dly);
      dmem.rsp_valid = (since >= 0) && (since == rsp_gap);
      dmem.rsp_rdata = dmem.rsp_valid ? rdata : 32'h0BAD_0BAD;
      @(negedge clk);
      if (stall) stalls++; else done = 1;
      hs   = dmem.req_valid && dmem.req_ready;
      seen = dmem.req_valid;
      @(posedge clk);
      if (hs) since = 0; else if (since >= 0) since++;
      if (seen) vcyc++;
      #1;
    end
    dmem.req_ready = 1'b0;
    dmem.rsp_valid = 1'b0;
    chk({tag, " stall cycles"}, 32'(stalls), 32'(exp_stall));
    chk({tag, " read_data"}, read_data, rd_q.pop_front());
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 1'b1; ex_rd = 1'b1; ex_wr = 1'b0; ex_addr = 32'h10; ex_wdata = '0;
    dmem.req_ready = 1'b0; dmem.rsp_valid = 1'b0; dmem.rsp_rdata = '0;
    exp_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset stall gated", 32'(stall), 32'd0);
    chk("reset req_valid",   32'(dmem.req_valid), 32'd0);
    chk("reset req_we",      32'(dmem.req_we), 32'd0);
    chk("reset req_addr",    dmem.req_addr, 32'h0);
    chk("reset req_wdata",   dmem.req_wdata, 32'h0);
    chk("reset read_data",   read_data, 32'h0);
    chk("reset misalign",    32'(misalign), 32'd0);
    chk("reset timeout",     32'(tmo), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; ex_valid = 1'b0;
    @(posedge clk); #1;

    do_access("load 0x10", 1'b1, 1'b0, 32'h10, 32'h0, 0, 0, 32'hCAFE_F00D, 3);
    do_access("store 0x20", 1'b0, 1'b1, 32'h20, 32'h1234_5678, 2, -1, 32'h0, 4);
    do_access("load 0x13 misaligned", 1'b1, 1'b0, 32'h13, 32'h0, 0, 0, 32'h0, 0);
    chk("misalign set", 32'(misalign), 32'd1);
    do_access("load 0x4", 1'b1, 1'b0, 32'h4, 32'h0, 0, 0, 32'h1111_1111, 3);
    do_access("load 0x8", 1'b1, 1'b0, 32'h8, 32'h0, 0, 0, 32'h2222_2222, 3);
    ex_valid = 1'b0;
    chk("misalign sticky", 32'(misalign), 32'd1);
    chk("timeout clear", 32'(tmo), 32'd0);

    do_access("load timeout", 1'b1, 1'b0, 32'h30, 32'h0, 0, -1, 32'h0, 5);
    ex_valid = 1'b0;
    chk("timeout set", 32'(tmo), 32'd1);
    @(posedge clk); #1;
    dmem.rsp_valid = 1'b1; dmem.rsp_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem.rsp_valid = 1'b0;
    @(negedge clk);
    chk("late rsp read_data", read_data, 32'h0);
    chk("late rsp stall", 32'(stall), 32'd0);
    @(posedge clk); #1;

    do_access("load 0x40", 1'b1, 1'b0, 32'h40, 32'h0, 0, 1, 32'h0F0F_0F0F, 4);
    ex_valid = 1'b0;
    chk("timeout sticky", 32'(tmo), 32'd1);

    // Reset while a load waits for its response
    req_q.push_back('{we: 1'b0, addr: 32'h50, wdata: 32'h0});
    ex_valid = 1'b1; ex_rd = 1'b1; ex_wr = 1'b0; ex_addr = 32'h50; ex_wdata = '0;
    dmem.req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dmem.req_ready = 1'b0;
    @(negedge clk);
    chk("wait stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; dmem.rsp_valid = 1'b1; dmem.rsp_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("mid reset stall gated", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    chk("post reset req_valid", 32'(dmem.req_valid), 32'd0);
    chk("post reset stall",     32'(stall), 32'd0);
    chk("post reset read_data", read_data, 32'h0);
    chk("post reset timeout",   32'(tmo), 32'd0);
    chk("post reset misalign",  32'(misalign), 32'd0);
    @(posedge clk); #1;
    dmem.rsp_valid = 1'b0;
    @(negedge clk);
    chk("stale rsp ignored", read_data, 32'h0);
    chk("req queue drained", 32'(req_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
